dcm_reset_seq: RTL and testbench

DCM_RESET_SEQ -- requirements
Module: dcm_reset_seq

---
 rtl/kawari_clk_pkg.sv | 26 ++
 rtl/sync2.sv | 21 ++
 rtl/dcm_reset_seq.sv | 127 ++++++++++++
 tb/tb_dcm_reset_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kawari_clk_pkg.sv
// Shared clock-bringup definitions: sequencer states, default timing constants
// and a small saturating-count helper.
package kawari_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_CHECK,
    ST_RUN,
    ST_FAIL
  } seq_state_e;

  localparam int          DEF_HOLD_CYCLES  = 64;
  localparam logic [15:0] DEF_LOCK_TIMEOUT = 16'd4096;
  localparam int          DEF_ACT_WINDOW   = 64;
  localparam int          DEF_MAX_RETRIES  = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    logic [7:0] r;
    r = v;
    if (inc && (v != 8'hFF)) r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level crossing into clk_in.
module sync2 (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_reset_seq.sv
// x4 DCM bring-up sequencer: holds the DCM in reset, waits for lock, verifies
// x4 activity via a heartbeat edge count, and retries a bounded number of times.
module dcm_reset_seq
  import kawari_clk_pkg::*;
#(
  parameter int          HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter logic [15:0] LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int          ACT_WINDOW   = DEF_ACT_WINDOW,
  parameter int          MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       chip_valid,
  input  logic       dcm_locked,
  input  logic       x4_heartbeat,
  output logic       dcm_reset,
  output logic       x4_ready,
  output logic       x4_fail,
  output logic [1:0] retry_count
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = LOCK_TIMEOUT - 16'd1;
  localparam logic [15:0] WIN_LAST  = 16'(ACT_WINDOW - 1);
  localparam logic [7:0]  EDGE_LO   = 8'(ACT_WINDOW / 4 - 2);
  localparam logic [7:0]  EDGE_HI   = 8'(ACT_WINDOW / 4 + 2);
  // retry_count is 2 bits wide, so the tolerance tops out at 3
  localparam logic [1:0]  RETRY_LIM = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

  seq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [1:0]  retry_q, retry_d;
  logic        lock_s, hb_s, hb_d1, hb_edge;
  logic        attempt_fail;

  sync2 u_sync_lock (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .d       (dcm_locked),
    .q       (lock_s)
  );

  sync2 u_sync_hb (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .d       (x4_heartbeat),
    .q       (hb_s)
  );

  // heartbeat is a toggle flop, so either transition is one x4 activity tick
  assign hb_edge     = hb_s ^ hb_d1;
  assign retry_count = retry_q;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q + 16'd1;
    ecnt_d       = ecnt_q;
    attempt_fail = 1'b0;

    if ((state_q != ST_IDLE) && !chip_valid) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (chip_valid) state_d = ST_HOLD;
        ST_HOLD:      if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s)                 state_d = ST_CHECK;
          else if (cnt_q == TMO_LAST) attempt_fail = 1'b1;
        end
        ST_CHECK: begin
          ecnt_d = sat_inc8(ecnt_q, hb_edge);
          if (!lock_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == WIN_LAST) begin
            if ((ecnt_d >= EDGE_LO) && (ecnt_d <= EDGE_HI)) state_d = ST_RUN;
            else                                            attempt_fail = 1'b1;
          end
        end
        ST_RUN:       if (!lock_s) attempt_fail = 1'b1;
        ST_FAIL:      ;
        default:      state_d = ST_IDLE;
      endcase
    end

    if (attempt_fail) begin
      if (retry_q < RETRY_LIM) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (state_d == ST_IDLE) retry_d = 2'd0;

    // every state entry starts its timeout/window fresh
    if (state_d != state_q) begin
      cnt_d  = '0;
      ecnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ecnt_q    <= '0;
      retry_q   <= '0;
      hb_d1     <= 1'b0;
      dcm_reset <= 1'b1;
      x4_ready  <= 1'b0;
      x4_fail   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ecnt_q    <= ecnt_d;
      retry_q   <= retry_d;
      hb_d1     <= hb_s;
      dcm_reset <= (state_d == ST_IDLE) || (state_d == ST_HOLD) || (state_d == ST_FAIL);
      x4_ready  <= (state_d == ST_RUN);
      x4_fail   <= (state_d == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_dcm_reset_seq.sv
// Bench for dcm_reset_seq: scenario table, hand-written corner sequences and
// randomized runs, all compared every cycle against a phase/age reference model.
module tb_dcm_reset_seq;

  localparam int HOLD = 64;
  localparam int WIN  = 64;
  localparam int TMO  = 4096;
  localparam int SYNC_LAT = 3;  // input edge -> value acted on by the sequencer

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b1;
  logic       chip_valid = 1'b0;
  logic       dcm_locked;
  logic       x4_heartbeat;
  logic       dcm_reset, x4_ready, x4_fail;
  logic [1:0] retry_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // environment knobs, written only by the main sequence
  int lock_delay = -1;
  int drop_at = -1;
  int hb_per = 0;
  bit hb_jit = 1'b0;
  int burst_start = -1;
  int burst_n = 0;

  dcm_reset_seq dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .chip_valid   (chip_valid),
    .dcm_locked   (dcm_locked),
    .x4_heartbeat (x4_heartbeat),
    .dcm_reset    (dcm_reset),
    .x4_ready     (x4_ready),
    .x4_fail      (x4_fail),
    .retry_count  (retry_count)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // DCM stand-in: loses lock while held in reset, relocks lock_delay cycles later
  initial begin : dcm_env
    int lcnt;
    lcnt = 0;
    dcm_locked = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (dcm_reset) lcnt = 0;
      else           lcnt++;
      dcm_locked = (lock_delay >= 0) && (lcnt > lock_delay) && (cyc != drop_at);
    end
  end

  // heartbeat stand-in: periodic toggles, or an exact burst of toggles
  initial begin : hb_env
    int hcnt, per;
    hcnt = 0;
    per = 4;
    x4_heartbeat = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (burst_start >= 0) begin
        if (cyc >= burst_start && cyc < burst_start + 2 * burst_n && ((cyc - burst_start) % 2) == 0)
          x4_heartbeat = ~x4_heartbeat;
      end else if (hb_per > 0) begin
        hcnt++;
        if (hcnt >= per) begin
          hcnt = 0;
          x4_heartbeat = ~x4_heartbeat;
          per = hb_per + (hb_jit ? int'($urandom_range(0, 1)) : 0);
        end
      end
    end
  end

  // reference model: phase + cycles spent in it; synchronizer delay is taken
  // from a history of sampled inputs rather than from modelled flops
  localparam int M_IDLE = 0, M_HOLD = 1, M_WAIT = 2, M_CHECK = 3, M_RUN = 4, M_FAIL = 5;
  int m_ph = M_IDLE, m_age = 0, m_edges = 0, m_retry = 0;
  bit lk_h [3];
  bit hb_h [4];

  task automatic model_step(input bit cv, input bit lk_in, input bit hb_in);
    bit lk, ed, bad;
    int nxt;
    lk_h[2] = lk_h[1]; lk_h[1] = lk_h[0]; lk_h[0] = lk_in;
    hb_h[3] = hb_h[2]; hb_h[2] = hb_h[1]; hb_h[1] = hb_h[0]; hb_h[0] = hb_in;
    lk = lk_h[2];
    ed = hb_h[2] ^ hb_h[3];
    nxt = m_ph;
    bad = 1'b0;
    if (m_ph == M_CHECK) m_edges += int'(ed);
    if (m_ph != M_IDLE && !cv) nxt = M_IDLE;
    else case (m_ph)
      M_IDLE:  if (cv) nxt = M_HOLD;
      M_HOLD:  if (m_age + 1 >= HOLD) nxt = M_WAIT;
      M_WAIT:  if (lk) nxt = M_CHECK; else if (m_age + 1 >= TMO) bad = 1'b1;
      M_CHECK: if (!lk) bad = 1'b1;
               else if (m_age + 1 >= WIN) begin
                 if (m_edges >= WIN / 4 - 2 && m_edges <= WIN / 4 + 2) nxt = M_RUN;
                 else bad = 1'b1;
               end
      M_RUN:   if (!lk) bad = 1'b1;
      default: ;
    endcase
    if (bad) begin
      if (m_retry < 3) begin m_retry++; nxt = M_HOLD; end
      else nxt = M_FAIL;
    end
    if (nxt == M_IDLE) m_retry = 0;
    if (nxt != m_ph) begin m_age = 0; m_edges = 0; end
    else m_age++;
    m_ph = nxt;
  endtask

  initial forever begin
    @(posedge clk_in);
    if (!reset_n) begin
      m_ph = M_IDLE; m_age = 0; m_edges = 0; m_retry = 0;
      lk_h = '{0, 0, 0};
      hb_h = '{0, 0, 0, 0};
    end else begin
      model_step(chip_valid, dcm_locked, x4_heartbeat);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic cycle_compare();
    logic [4:0] got, exp;
    got = {dcm_reset, x4_ready, x4_fail, retry_count};
    if (!reset_n) exp = {1'b1, 1'b0, 1'b0, 2'd0};
    else exp = {(m_ph == M_IDLE || m_ph == M_HOLD || m_ph == M_FAIL), (m_ph == M_RUN),
                (m_ph == M_FAIL), 2'(m_retry)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cmp @cyc %0d: got rst/rdy/fail/retry=%b expected %b (phase %0d)",
               cyc, got, exp, m_ph);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #2;
      cycle_compare();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    chip_valid = 1'b0;
    lock_delay = -1;
    drop_at = -1;
    hb_per = 0;
    hb_jit = 1'b0;
    burst_start = -1;
    burst_n = 0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  typedef struct {
    int lock_delay;
    int hb_per;
    int cycles;
    bit exp_ready;
    bit exp_fail;
    int exp_retry;
  } scn_t;

  scn_t tbl [7];
  int hb_sel [8] = '{2, 3, 4, 4, 4, 5, 0, 8};
  int cnt_tbl [4] = '{13, 14, 18, 19};

  initial begin : main
    int n, t_cv, t_fall, t_lock, t_ready, ev, ev_t;
    bit pass;

    tbl[0] = '{200, 4, 1000, 1'b1, 1'b0, 0};   // nominal: 16 edges per window
    tbl[1] = '{200, 2, 2000, 1'b0, 1'b1, 3};   // 2x heartbeat: 32 edges
    tbl[2] = '{50,  0, 1200, 1'b0, 1'b1, 3};   // stuck heartbeat
    tbl[3] = '{50,  8, 1200, 1'b0, 1'b1, 3};   // half-rate: 8 edges
    tbl[4] = '{50,  3, 1200, 1'b0, 1'b1, 3};   // 21-22 edges
    tbl[5] = '{0,   4, 500,  1'b1, 1'b0, 0};   // immediate lock
    tbl[6] = '{-1,  4, 17000, 1'b0, 1'b1, 3};  // lock never arrives

    #1 reset_n = 1'b0;
    tick(2);
    check("reset_dcm_reset", dcm_reset, 1);
    check("reset_x4_ready", x4_ready, 0);
    check("reset_x4_fail", x4_fail, 0);
    check("reset_retry", retry_count, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      lock_delay = tbl[i].lock_delay;
      hb_per = tbl[i].hb_per;
      chip_valid = 1'b1;
      tick(tbl[i].cycles);
      check($sformatf("scn%0d_ready", i), x4_ready, tbl[i].exp_ready);
      check($sformatf("scn%0d_fail", i), x4_fail, tbl[i].exp_fail);
      check($sformatf("scn%0d_retry", i), retry_count, tbl[i].exp_retry);
      check($sformatf("scn%0d_dcm_reset", i), dcm_reset, tbl[i].exp_fail);
      if (tbl[i].exp_fail) begin
        chip_valid = 1'b0;
        tick(1);
        check($sformatf("scn%0d_fail_exit", i), {x4_fail, dcm_reset, retry_count}, 4'b0100);
      end
    end

    // nominal bring-up timing with chip_valid rising at cycle 10
    do_reset();
    hb_per = 4;
    lock_delay = 200;
    tick(10);
    chip_valid = 1'b1;
    t_cv = cyc;
    n = 0;
    while (dcm_reset !== 1'b0 && n < 500) begin tick(); n++; end
    t_fall = cyc;
    check("hold_len", t_fall - t_cv - 1, HOLD);
    n = 0;
    while (dcm_locked !== 1'b1 && n < 500) begin tick(); n++; end
    t_lock = cyc;
    check("lock_after_fall", t_lock - t_fall, 200);
    n = 0;
    while (x4_ready !== 1'b1 && n < 500) begin tick(); n++; end
    t_ready = cyc;
    check("ready_latency", t_ready - t_lock, SYNC_LAT + WIN);
    check("nominal_retry", retry_count, 0);

    // exact heartbeat counts at the acceptance boundaries
    for (int k = 0; k < 4; k++) begin
      do_reset();
      lock_delay = 0;
      chip_valid = 1'b1;
      n = 0;
      while (dcm_locked !== 1'b1 && n < 300) begin tick(); n++; end
      t_lock = cyc;
      burst_start = t_lock + 5;
      burst_n = cnt_tbl[k];
      tick(SYNC_LAT + WIN + 8);
      pass = (cnt_tbl[k] >= 14 && cnt_tbl[k] <= 18);
      check($sformatf("count%0d_ready", cnt_tbl[k]), x4_ready, pass);
      check($sformatf("count%0d_retry", cnt_tbl[k]), retry_count, pass ? 0 : 1);
      check($sformatf("count%0d_dcm_reset", cnt_tbl[k]), dcm_reset, pass ? 0 : 1);
    end

    // stuck heartbeat fails once, then runs after the heartbeat recovers
    do_reset();
    lock_delay = 20;
    chip_valid = 1'b1;
    n = 0;
    while (retry_count !== 2'd1 && n < 1000) begin tick(); n++; end
    check("stuck_retry1", retry_count, 1);
    check("stuck_rehold", dcm_reset, 1);
    hb_per = 4;
    n = 0;
    while (x4_ready !== 1'b1 && n < 1000) begin tick(); n++; end
    check("fixed_ready", x4_ready, 1);
    check("fixed_retry", retry_count, 1);

    // one-cycle lock loss while running
    do_reset();
    lock_delay = 20;
    hb_per = 4;
    chip_valid = 1'b1;
    n = 0;
    while (x4_ready !== 1'b1 && n < 1000) begin tick(); n++; end
    tick(5);
    drop_at = cyc + 2;
    n = 0;
    while (x4_ready !== 1'b0 && n < 50) begin tick(); n++; end
    check("drop_ready_low", x4_ready, 0);
    check("drop_dcm_reset", dcm_reset, 1);
    check("drop_retry", retry_count, 1);
    n = 0;
    while (dcm_reset === 1'b1 && n < 200) begin n++; tick(); end
    check("drop_rehold_len", n, HOLD);
    n = 0;
    while (x4_ready !== 1'b1 && n < 1000) begin tick(); n++; end
    check("drop_recover_retry", retry_count, 1);

    // chip_valid falls during WAIT_LOCK with a retry already recorded
    do_reset();
    lock_delay = 100;
    chip_valid = 1'b1;
    n = 0;
    while (retry_count !== 2'd1 && n < 1000) begin tick(); n++; end
    n = 0;
    while (dcm_reset !== 1'b0 && n < 200) begin tick(); n++; end
    tick(10);
    chip_valid = 1'b0;
    tick(1);
    check("cvfall_outputs", {dcm_reset, x4_ready, x4_fail, retry_count}, 5'b10000);

    // reset_n pulse during CHECK of a second attempt
    do_reset();
    lock_delay = 20;
    chip_valid = 1'b1;
    n = 0;
    while (retry_count !== 2'd1 && n < 1000) begin tick(); n++; end
    n = 0;
    while (dcm_locked !== 1'b1 && n < 300) begin tick(); n++; end
    hb_per = 4;
    tick(10);
    reset_n = 1'b0;
    #1;
    check("rstpulse_outputs", {dcm_reset, x4_ready, x4_fail, retry_count}, 5'b10000);
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check("rstpulse_restart", {dcm_reset, x4_ready}, 2'b10);

    // randomized runs with one disturbance each
    for (int it = 0; it < 12; it++) begin
      do_reset();
      lock_delay = int'($urandom_range(0, 300));
      hb_per = hb_sel[$urandom_range(0, 7)];
      hb_jit = 1'($urandom_range(0, 1));
      chip_valid = 1'b1;
      ev = int'($urandom_range(0, 3));
      ev_t = cyc + int'($urandom_range(50, 900));
      for (int c = 0; c < 1200; c++) begin
        if (cyc == ev_t) begin
          case (ev)
            0: hb_per = 4;
            1: drop_at = cyc + 2;
            2: chip_valid = 1'b0;
            default: reset_n = 1'b0;
          endcase
        end
        if (cyc == ev_t + 4) begin
          chip_valid = 1'b1;
          reset_n = 1'b1;
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
